// File: rtl/hb_int_strobe_sched.sv
// rtl/hb_int_strobe_sched.sv - strobe scheduler for the two-stage halfband + CIC interpolation chain
module hb_int_strobe_sched #(
   parameter int RATE_WIDTH = 8,
   parameter int MIN_GAP    = 7
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  run,
   input  logic [RATE_WIDTH-1:0] rate,
   input  logic                  en_hb1,
   input  logic                  en_hb2,
   input  logic                  sample_rdy,
   output logic                  sample_ack,
   output logic                  stb_hb1_in,
   output logic                  stb_hb1_out,
   output logic                  stb_hb2_in,
   output logic                  stb_hb2_out,
   output logic                  stb_cic,
   output logic                  cfg_err,
   output logic                  underrun,
   output logic                  busy
);

   localparam int PW = RATE_WIDTH + 2;

   typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_ERR} state_t;

   state_t                state_q, state_d;
   logic [RATE_WIDTH-1:0] cnt_q, cnt_d, cnt_nxt;
   logic [RATE_WIDTH-1:0] rate_q, rate_d;
   logic                  en1_q, en1_d, en2_q, en2_d;
   logic                  ph1_q, ph1_d, ph2_q, ph2_d;
   logic                  ack_q, ack_d, h1i_q, h1i_d, h2i_q, h2i_d, cic_q, cic_d;
   logic                  cfg_err_q, cfg_err_d, under_q, under_d, busy_q, busy_d;
   logic                  fire;
   logic [PW-1:0]         rate_x, p2, p1;
   logic                  cfg_bad;

   // Validity is judged on the live inputs, at the same moment they are latched.
   assign rate_x  = PW'(rate);
   assign p2      = en_hb2 ? (rate_x << 1) : rate_x;
   assign p1      = en_hb1 ? (p2 << 1) : p2;
   assign cfg_bad = (rate == '0) ||
                    (en_hb2 && (p2 < PW'(MIN_GAP))) ||
                    (en_hb1 && (p1 < PW'(MIN_GAP)));

   assign cnt_nxt = (cnt_q == rate_q - RATE_WIDTH'(1)) ? '0 : cnt_q + RATE_WIDTH'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rate_d  = rate_q;
      en1_d   = en1_q;
      en2_d   = en2_q;
      ph1_d   = ph1_q;
      ph2_d   = ph2_q;
      under_d = under_q;
      ack_d   = 1'b0;
      h1i_d   = 1'b0;
      h2i_d   = 1'b0;
      cic_d   = 1'b0;
      fire    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (run) begin
               rate_d = rate;
               en1_d  = en_hb1;
               en2_d  = en_hb2;
               if (cfg_bad) begin
                  state_d = S_ERR;
               end else begin
                  state_d = S_PRIME;
                  under_d = 1'b0;
               end
            end
         end
         S_ERR: begin
            if (!run) state_d = S_IDLE;
         end
         S_PRIME: begin
            if (!run) begin
               state_d = S_IDLE;
            end else if (sample_rdy) begin
               state_d = S_RUN;
               fire    = 1'b1;
               cnt_d   = cnt_nxt;
            end
         end
         S_RUN: begin
            if (!run) begin
               state_d = S_IDLE;
            end else begin
               fire  = (cnt_q == '0);
               cnt_d = cnt_nxt;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Phase bits gate each stage down to every other strobe of the stage below it.
      if (fire) begin
         cic_d = 1'b1;
         h2i_d = !en2_q || !ph2_q;
         if (en2_q) ph2_d = !ph2_q;
         h1i_d = h2i_d && (!en1_q || !ph1_q);
         if (h2i_d && en1_q) ph1_d = !ph1_q;
         ack_d = h1i_d && sample_rdy;
         if (h1i_d && !sample_rdy && (state_q == S_RUN)) under_d = 1'b1;
      end

      if (state_d == S_IDLE) begin
         cnt_d = '0;
         ph1_d = 1'b0;
         ph2_d = 1'b0;
      end

      cfg_err_d = (state_d == S_ERR);
      busy_d    = (state_d == S_PRIME) || (state_d == S_RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rate_q    <= '0;
         en1_q     <= 1'b0;
         en2_q     <= 1'b0;
         ph1_q     <= 1'b0;
         ph2_q     <= 1'b0;
         ack_q     <= 1'b0;
         h1i_q     <= 1'b0;
         h2i_q     <= 1'b0;
         cic_q     <= 1'b0;
         cfg_err_q <= 1'b0;
         under_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rate_q    <= rate_d;
         en1_q     <= en1_d;
         en2_q     <= en2_d;
         ph1_q     <= ph1_d;
         ph2_q     <= ph2_d;
         ack_q     <= ack_d;
         h1i_q     <= h1i_d;
         h2i_q     <= h2i_d;
         cic_q     <= cic_d;
         cfg_err_q <= cfg_err_d;
         under_q   <= under_d;
         busy_q    <= busy_d;
      end
   end

   // Stage 1 output feeds stage 2 input, and stage 2 output feeds the CIC.
   assign sample_ack  = ack_q;
   assign stb_hb1_in  = h1i_q;
   assign stb_hb1_out = h2i_q;
   assign stb_hb2_in  = h2i_q;
   assign stb_hb2_out = cic_q;
   assign stb_cic     = cic_q;
   assign cfg_err     = cfg_err_q;
   assign underrun    = under_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_hb_int_strobe_sched.sv
// tb/tb_hb_int_strobe_sched.sv - scoreboard bench for hb_int_strobe_sched
module tb_hb_int_strobe_sched;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run = 1'b0;
   logic [7:0] rate = 8'd0;
   logic       en_hb1 = 1'b0;
   logic       en_hb2 = 1'b0;
   logic       sample_rdy = 1'b0;
   logic       sample_ack, stb_hb1_in, stb_hb1_out, stb_hb2_in, stb_hb2_out, stb_cic;
   logic       cfg_err, underrun, busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic [8:0] sb[$];

   // Reference: strobes are multiples of each stage period counted from the first set.
   int m_state = 0;
   int m_k = 0;
   int m_rate = 1, m_p2 = 1, m_p1 = 1;
   logic m_under = 1'b0;

   hb_int_strobe_sched #(.RATE_WIDTH(8), .MIN_GAP(7)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .rate(rate),
      .en_hb1(en_hb1), .en_hb2(en_hb2), .sample_rdy(sample_rdy),
      .sample_ack(sample_ack), .stb_hb1_in(stb_hb1_in), .stb_hb1_out(stb_hb1_out),
      .stb_hb2_in(stb_hb2_in), .stb_hb2_out(stb_hb2_out), .stb_cic(stb_cic),
      .cfg_err(cfg_err), .underrun(underrun), .busy(busy)
   );

   always #5 clk = ~clk;

   wire [8:0] obs = {sample_ack, stb_hb1_in, stb_hb1_out, stb_hb2_in, stb_hb2_out,
                     stb_cic, cfg_err, underrun, busy};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
      end
   endtask

   initial begin
      forever begin
         logic a, h1i, h2i, c;
         int ns;
         @(posedge clk);
         if (!rst_n) begin
            m_state = 0;
            m_k     = 0;
            m_under = 1'b0;
            sb.push_back(9'd0);
         end else begin
            a = 1'b0; h1i = 1'b0; h2i = 1'b0; c = 1'b0;
            ns = m_state;
            case (m_state)
               0: if (run) begin
                  m_rate = int'(rate);
                  m_p2   = en_hb2 ? 2 * m_rate : m_rate;
                  m_p1   = en_hb1 ? 2 * m_p2 : m_p2;
                  if (m_rate == 0 || (en_hb2 && m_p2 < 7) || (en_hb1 && m_p1 < 7)) ns = 3;
                  else begin
                     ns = 1;
                     m_under = 1'b0;
                  end
               end
               3: if (!run) ns = 0;
               1: if (!run) ns = 0;
                  else if (sample_rdy) begin
                     ns = 2;
                     a = 1'b1; h1i = 1'b1; h2i = 1'b1; c = 1'b1;
                     m_k = 1;
                  end
               default: if (!run) ns = 0;
                  else begin
                     if (m_k % m_rate == 0) c = 1'b1;
                     if (m_k % m_p2 == 0) h2i = 1'b1;
                     if (m_k % m_p1 == 0) begin
                        h1i = 1'b1;
                        a   = sample_rdy;
                        if (!sample_rdy) m_under = 1'b1;
                     end
                     m_k++;
                  end
            endcase
            m_state = ns;
            sb.push_back({a, h1i, h2i, h2i, c, c, ns == 3, m_under, ns == 1 || ns == 2});
         end
      end
   end

   initial begin
      forever begin
         logic [8:0] e;
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("cyc", 32'(obs), 32'(e));
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start(input int r, input logic e1, input logic e2);
      rate = 8'(r); en_hb1 = e1; en_hb2 = e2; run = 1'b1;
   endtask

   initial begin
      bit found;
      cyc(2);
      check("rst_state", 32'(obs), 32'd0);
      rst_n = 1'b1;
      cyc(3);

      sample_rdy = 1'b1;
      start(4, 1'b1, 1'b1); cyc(40);
      run = 1'b0; cyc(3);

      start(3, 1'b0, 1'b1); cyc(5);
      run = 1'b0; cyc(2);
      start(4, 1'b1, 1'b0); cyc(20);
      run = 1'b0; cyc(2);

      start(0, 1'b0, 1'b0); cyc(3);
      run = 1'b0; cyc(2);
      start(1, 1'b0, 1'b0); cyc(6);
      run = 1'b0; cyc(2);

      start(2, 1'b1, 1'b1); cyc(10);
      sample_rdy = 1'b0; cyc(8);
      sample_rdy = 1'b1; cyc(20);
      run = 1'b0; cyc(2);
      run = 1'b1; cyc(12);
      run = 1'b0; cyc(2);

      sample_rdy = 1'b0;
      start(4, 1'b1, 1'b1); cyc(10);
      sample_rdy = 1'b1; cyc(20);
      run = 1'b0; cyc(2);

      start(4, 1'b0, 1'b0); cyc(10);
      rate = 8'd8; cyc(20);
      run = 1'b0; cyc(2);
      run = 1'b1; cyc(30);

      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (m_state == 2 && (m_k % m_rate) == 0) begin
            found = 1'b1;
            break;
         end
         cyc(1);
      end
      check("align_found", 32'(found), 32'd1);
      #2 rst_n = 1'b0;
      #1 check("rst_mid", 32'(obs), 32'd0);
      cyc(1);
      rst_n = 1'b1;
      cyc(30);
      run = 1'b0; cyc(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
